multicycle_chunk_adder: RTL and testbench
=========================================

// Module: multicycle_chunk_adder
// PURPOSE
//  Parametrised multi-cycle ripple adder/subtractor; successor to the fixed 2-bit full_adder chain.
//  Adds WIDTH-bit operands CHUNK bits per clock through a CHUNK-long full_adder chain,
//  carrying between chunks in a register; start/busy/done handshake.
//  Used where wide adds must trade latency for area in lab datapaths.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; WIDTH % CHUNK == 0 (else $error at elaboration)
//  CHUNK  2  bits added per cycle (full_adder instances in chain); 1..WIDTH
//  derived: STEPS = WIDTH/CHUNK, index counter width = max(1,$clog2(STEPS))
// PORTS
//  clk    in   1      rising-edge clock
//  reset  in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only in IDLE or DONE
//  a      in   WIDTH  operand A, captured on accepted start
//  b      in   WIDTH  operand B, captured on accepted start
//  cin    in   1      carry-in for add; ignored when sub=1
//  sub    in   1      0: s=a+b+cin; 1: s=a+~b+1 (a-b), captured on accepted start
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse: s/cout (and ovf) newly valid
//  s      out  WIDTH  result; holds last completed value until next completion
//  cout   out  1      carry out of MSB (for sub: 1 = no borrow)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, done=0, s=0, cout=0, working regs=0;
//   in-flight op discarded, no done pulse for it.
//  States: IDLE --start--> RUN; RUN --idx==STEPS-1--> DONE; DONE --start--> RUN, else IDLE.
//  Accept (edge E0, start=1 in IDLE/DONE): A_r=a; B_r= sub ? ~b : b; c_r= sub ? 1 : cin; idx=0.
//  RUN edge Ek (k=1..STEPS): {c_r, W[idx*CHUNK +: CHUNK]} = A_r[chunk]+B_r[chunk]+c_r; idx++.
//   Chunk 0 = LSBs; ripple inside chunk via full_adder chain.
//  At edge E_STEPS: s=final W, cout=final carry, state=DONE, done=1 for that cycle only.
//  Latency: done high in the cycle following E_STEPS (STEPS cycles after accept edge).
//  busy=1 exactly for cycles between E0 and E_STEPS; busy=0 in IDLE and DONE.
//  start while RUN: ignored, operands unchanged, no queuing.
//  start in DONE: accepted back-to-back; done still pulses (1 cycle); s holds until next completion.
//  a/b/cin/sub changes after accept: no effect on in-flight op.
//  Arithmetic modulo 2^WIDTH; cout as in WIDTH-bit add; no saturation.
//  CHUNK==WIDTH: STEPS=1, done one cycle after accept.
//  s and cout never show partial sums (working reg W is internal).
// CONFIGURATION
//  OVERFLOW_FLAG_EN defined: extra output ovf (1 bit) = signed overflow
//   = carry into MSB XOR carry out of MSB; loaded with s at E_STEPS; reset 0; held like s.
//  Not defined: ovf port and its logic absent; all other behaviour identical.
// TESTING (WIDTH=8, CHUNK=2 unless noted)
//  a=FF,b=01,cin=0,sub=0,start 1 cycle -> busy 4 cycles; done pulse 1 cycle; s=00,cout=1.
//  sub=1,a=05,b=03 -> s=02,cout=1; sub=1,a=03,b=05,cin=1 (ignored) -> s=FE,cout=0.
//  start pulsed again mid-RUN with a=11,b=22 -> ignored; first result intact; one done only.
//  reset asserted 2 cycles into RUN -> immediately busy=0,done=0,s=0,cout=0; no done afterwards.
//  start held high across DONE with new operands -> back-to-back ops, done every 5th cycle, s updates each.
//  OVERFLOW_FLAG_EN: a=7F,b=01 -> s=80,ovf=1; CHUNK=8 build: a=80,b=80 -> done after 1 cycle, s=00,cout=1.

Source files
------------

// File: rtl/multicycle_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_chunk_adder (with helper full_adder)
// Purpose  : Multi-cycle ripple adder/subtractor. WIDTH-bit operands are
//            processed CHUNK bits per clock through a CHUNK-long full_adder
//            chain. The carry between chunks is held in a register.
//            The handshake is start/busy/done.
// Ports    : clk, reset (async, active-high), start, a, b, cin, sub
//            -> busy, done (1-cycle pulse), s, cout
//            [ovf when OVERFLOW_FLAG_EN is defined]
// Config   : OVERFLOW_FLAG_EN adds the signed-overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module multicycle_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);
    localparam int STEPS = WIDTH / CHUNK;
    localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(STEPS - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
            $error("multicycle_chunk_adder: CHUNK must be 1..WIDTH and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [WIDTH-1:0] r_w;
    logic [IDX_W-1:0] r_idx;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_sum;
    logic [CHUNK:0]   w_carry;
    logic [WIDTH-1:0] w_w_next;

    // Current chunk of the captured operands; chunk 0 holds the LSBs.
    assign w_a_chunk  = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk  = r_b[r_idx*CHUNK +: CHUNK];
    assign w_carry[0] = r_c;

    generate
        for (genvar i = 0; i < CHUNK; i++) begin : g_fa_chain
            full_adder u_fa (
                .a    (w_a_chunk[i]),
                .b    (w_b_chunk[i]),
                .cin  (w_carry[i]),
                .s    (w_sum[i]),
                .cout (w_carry[i+1])
            );
        end
    endgenerate

    // The working word with this cycle's chunk merged in. On the last step
    // this is the complete result, so s never sees a partial sum.
    always_comb begin
        w_w_next = r_w;
        w_w_next[r_idx*CHUNK +: CHUNK] = w_sum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_idx == C_LAST_IDX) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // DONE lasts exactly one cycle, so it doubles as the done pulse.
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_w   <= '0;
            r_idx <= '0;
            s     <= '0;
            cout  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1: invert B and force the carry-in to 1.
            r_a   <= a;
            r_b   <= sub ? ~b : b;
            r_c   <= sub ? 1'b1 : cin;
            r_idx <= '0;
        end else if (r_state == S_RUN) begin
            r_w   <= w_w_next;
            r_c   <= w_carry[CHUNK];
            r_idx <= r_idx + 1'b1;
            if (w_last) begin
                s    <= w_w_next;
                cout <= w_carry[CHUNK];
`ifdef OVERFLOW_FLAG_EN
                // The final chunk contains the MSB, so the carry into the MSB
                // is the carry entering the top full adder of the chain.
                ovf  <= w_carry[CHUNK] ^ w_carry[CHUNK-1];
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_chunk_adder
// Purpose  : Self-checking bench for multicycle_chunk_adder. It uses a
//            WIDTH=8 / CHUNK=2 instance and a CHUNK=8 instance. Results are
//            compared against an integer arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_chunk_adder;
    localparam int W     = 8;
    localparam int CH    = 2;
    localparam int STEPS = W / CH;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         start8;
    logic         cin;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy, done, cout;
    logic [W-1:0] s;
    logic         busy8, done8, cout8;
    logic [W-1:0] s8;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf, ovf8;
`endif

    int checks = 0;
    int errors = 0;

    multicycle_chunk_adder #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
`ifdef OVERFLOW_FLAG_EN
        , .ovf (ovf)
`endif
    );

    multicycle_chunk_adder #(.WIDTH(W), .CHUNK(W)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy8),
        .done  (done8),
        .s     (s8),
        .cout  (cout8)
`ifdef OVERFLOW_FLAG_EN
        , .ovf (ovf8)
`endif
    );

    always #5 clk = ~clk;

    // Reference: {cout, s} from plain integer arithmetic.
    function automatic logic [W:0] ref_result(input int x, input int y, input logic c, input logic sb);
        int t;
        logic [W:0] r;
        if (sb) begin
            t = (x - y) & ((1 << W) - 1);
            r = {(x >= y) ? 1'b1 : 1'b0, t[W-1:0]};
        end else begin
            t = x + y + int'(c);
            r = t[W:0];
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int x, input int y, input logic c, input logic sb);
        int sx, sy, r;
        sx = (x >= (1 << (W-1))) ? x - (1 << W) : x;
        sy = (y >= (1 << (W-1))) ? y - (1 << W) : y;
        r  = sb ? (sx - sy) : (sx + sy + int'(c));
        return (r < -(1 << (W-1))) || (r > (1 << (W-1)) - 1);
    endfunction

    task automatic run_op(input int ta, input int tb2, input logic tc, input logic ts, input string tag);
        logic [W:0]   exp;
        logic [W-1:0] held;
        exp = ref_result(ta, tb2, tc, ts);
        @(negedge clk);
        a = W'(ta); b = W'(tb2); cin = tc; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < STEPS; n++) begin
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++;
                $display("FAIL %s busy/done cycle %0d: got %b%b, expected 10", tag, n, busy, done);
            end
            @(negedge clk);
        end
        checks++;
        if ({busy, done, cout, s} !== {2'b01, exp}) begin
            errors++;
            $display("FAIL %s result: busy=%b done=%b cout=%b s=%h, expected busy=0 done=1 cout=%b s=%h",
                     tag, busy, done, cout, s, exp[W], exp[W-1:0]);
        end
`ifdef OVERFLOW_FLAG_EN
        checks++;
        if (ovf !== ref_ovf(ta, tb2, tc, ts)) begin
            errors++;
            $display("FAIL %s ovf: got %b, expected %b", tag, ovf, ref_ovf(ta, tb2, tc, ts));
        end
`endif
        held = s;
        @(negedge clk);
        checks++;
        if ({done, s} !== {1'b0, held}) begin
            errors++;
            $display("FAIL %s hold: done=%b s=%h, expected done=0 s=%h", tag, done, s, held);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; start8 = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cout, s} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b cout=%b s=%h, expected all 0", busy, done, cout, s);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, cout, s} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b cout=%b s=%h, expected all 0", busy, done, cout, s);
        end
    endtask

    task automatic test_directed;
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
        run_op(8'h05, 8'h03, 1'b0, 1'b1, "sub_05_03");
        run_op(8'h03, 8'h05, 1'b1, 1'b1, "sub_03_05_cin");
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, "add_ff_ff_cin");
        run_op(8'h00, 8'h00, 1'b0, 1'b1, "sub_00_00");
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_overflow;
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, "ovf_7f_01");
        run_op(8'h80, 8'h01, 1'b0, 1'b1, "ovf_80_m01");
        run_op(8'h40, 8'h3F, 1'b0, 1'b0, "no_ovf_40_3f");
    endtask

    task automatic test_start_mid_run;
        int extra_done;
        @(negedge clk);
        a = 8'h3C; b = 8'h15; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b1; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({done, cout, s} !== {1'b1, 1'b0, 8'h51}) begin
            errors++;
            $display("FAIL start_mid_run result: done=%b cout=%b s=%h, expected done=1 cout=0 s=51", done, cout, s);
        end
        extra_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        checks++;
        if (extra_done !== 0) begin
            errors++;
            $display("FAIL start_mid_run extra activity: %0d cycles with busy/done, expected 0", extra_done);
        end
    endtask

    task automatic test_reset_mid_run;
        int late;
        run_op(8'h12, 8'h34, 1'b0, 1'b0, "pre_reset");
        @(negedge clk);
        a = 8'hA5; b = 8'h5A; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, cout, s} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b cout=%b s=%h, expected all 0", busy, done, cout, s);
        end
        @(negedge clk);
        reset = 1'b0;
        late = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1 || s !== '0) late++;
        end
        checks++;
        if (late !== 0) begin
            errors++;
            $display("FAIL reset_mid_run aftermath: %0d bad cycles, expected 0", late);
        end
    endtask

    task automatic test_back_to_back;
        int   oa [4];
        int   ob [4];
        logic oc [4];
        logic os [4];
        int   gap;
        logic [W:0] exp;
        for (int i = 0; i < 4; i++) begin
            oa[i] = int'($urandom_range(0, 255));
            ob[i] = int'($urandom_range(0, 255));
            oc[i] = 1'($urandom_range(0, 1));
            os[i] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        a = W'(oa[0]); b = W'(ob[0]); cin = oc[0]; sub = os[0]; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = ref_result(oa[i], ob[i], oc[i], os[i]);
            gap = 0;
            while (1) begin
                @(negedge clk);
                gap++;
                if (done === 1'b1 || gap >= 20) break;
            end
            checks++;
            if (gap !== STEPS + 1 || {cout, s} !== exp) begin
                errors++;
                $display("FAIL back_to_back op %0d: gap=%0d cout=%b s=%h, expected gap=%0d cout=%b s=%h",
                         i, gap, cout, s, STEPS + 1, exp[W], exp[W-1:0]);
            end
            if (i < 3) begin
                a = W'(oa[i+1]); b = W'(ob[i+1]); cin = oc[i+1]; sub = os[i+1];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL back_to_back end: busy=%b done=%b, expected 00", busy, done);
        end
    endtask

    task automatic test_chunk_full_width;
        int ta, tb2;
        logic tc, ts;
        logic [W:0] exp;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                ta = 8'h80; tb2 = 8'h80; tc = 1'b0; ts = 1'b0;
            end else begin
                ta = int'($urandom_range(0, 255)); tb2 = int'($urandom_range(0, 255));
                tc = 1'($urandom_range(0, 1)); ts = 1'($urandom_range(0, 1));
            end
            exp = ref_result(ta, tb2, tc, ts);
            @(negedge clk);
            a = W'(ta); b = W'(tb2); cin = tc; sub = ts; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            checks++;
            if ({busy8, done8} !== 2'b10) begin
                errors++;
                $display("FAIL chunk8 op %0d busy: busy=%b done=%b, expected 10", i, busy8, done8);
            end
            @(negedge clk);
            checks++;
            if ({busy8, done8, cout8, s8} !== {2'b01, exp}) begin
                errors++;
                $display("FAIL chunk8 op %0d result: busy=%b done=%b cout=%b s=%h, expected 0 1 %b %h",
                         i, busy8, done8, cout8, s8, exp[W], exp[W-1:0]);
            end
`ifdef OVERFLOW_FLAG_EN
            checks++;
            if (ovf8 !== ref_ovf(ta, tb2, tc, ts)) begin
                errors++;
                $display("FAIL chunk8 op %0d ovf: got %b, expected %b", i, ovf8, ref_ovf(ta, tb2, tc, ts));
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_overflow();
        test_start_mid_run();
        test_reset_mid_run();
        test_back_to_back();
        test_chunk_full_width();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
